// File: rtl/matrix_wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter for the 8x8 LED matrix
// register slave. Master 0 is the CPU bus bridge, master 1 the animation engine.
//
// The grant is held for the whole bus cycle (cyc high). When several masters
// are waiting, round-robin arbitration picks the next one.
// Accepted requests are counted per grant. The count limits how many may be
// outstanding, and it filters slave acks that belong to no request.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   i_mN_wb_*              master N request (cyc, stb, we, addr, sel, wdata)
//   o_mN_wb_*              master N response (ack, stall, rdata)
//   o_s_wb_*               request muxed to the slave
//   i_s_wb_*               slave response (ack, stall, rdata)
//   o_grant                one-hot registered grant (bit0 = m0, bit1 = m1)
//   o_timeout              synthetic-ack pulse (only with MATRIX_ARB_TIMEOUT_EN)
//
// Optional feature: define MATRIX_ARB_TIMEOUT_EN to add a slave-response
// timeout. It returns a synthetic ack (rdata 0) after TIMEOUT_CYCLES stuck cycles.
// MAX_OUTSTANDING must be in the range 1..15.

module matrix_wb_arbiter #(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 3,
    parameter int WB_SEL_WIDTH    = WB_DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     i_m0_wb_cyc,
    input  logic                     i_m0_wb_stb,
    input  logic                     i_m0_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_m0_wb_addr,
    input  logic [WB_SEL_WIDTH-1:0]  i_m0_wb_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_m0_wb_wdata,
    output logic                     o_m0_wb_ack,
    output logic                     o_m0_wb_stall,
    output logic [WB_DATA_WIDTH-1:0] o_m0_wb_rdata,

    input  logic                     i_m1_wb_cyc,
    input  logic                     i_m1_wb_stb,
    input  logic                     i_m1_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_m1_wb_addr,
    input  logic [WB_SEL_WIDTH-1:0]  i_m1_wb_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_m1_wb_wdata,
    output logic                     o_m1_wb_ack,
    output logic                     o_m1_wb_stall,
    output logic [WB_DATA_WIDTH-1:0] o_m1_wb_rdata,

    output logic                     o_s_wb_cyc,
    output logic                     o_s_wb_stb,
    output logic                     o_s_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_s_wb_addr,
    output logic [WB_SEL_WIDTH-1:0]  o_s_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_s_wb_wdata,
    input  logic                     i_s_wb_ack,
    input  logic                     i_s_wb_stall,
    input  logic [WB_DATA_WIDTH-1:0] i_s_wb_rdata,

    output logic [1:0]               o_grant
`ifdef MATRIX_ARB_TIMEOUT_EN
    ,
    output logic                     o_timeout
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            last_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            granted;
    logic            sel1;
    logic            m_cyc;
    logic            m_stb;
    logic            m_we;
    logic [WB_ADDR_WIDTH-1:0] m_addr;
    logic [WB_SEL_WIDTH-1:0]  m_sel;
    logic [WB_DATA_WIDTH-1:0] m_wdata;

    logic            cnt_nz;
    logic            limit;
    logic            ack_ok;
    logic            tmo;
    logic            accept;
    logic            dec;
    logic            release_grant;

    assign granted = (state != IDLE);
    assign sel1    = (state == GRANT1);

    assign m_cyc   = sel1 ? i_m1_wb_cyc   : i_m0_wb_cyc;
    assign m_stb   = sel1 ? i_m1_wb_stb   : i_m0_wb_stb;
    assign m_we    = sel1 ? i_m1_wb_we    : i_m0_wb_we;
    assign m_addr  = sel1 ? i_m1_wb_addr  : i_m0_wb_addr;
    assign m_sel   = sel1 ? i_m1_wb_sel   : i_m0_wb_sel;
    assign m_wdata = sel1 ? i_m1_wb_wdata : i_m0_wb_wdata;

    assign cnt_nz  = (cnt != '0);
    assign limit   = granted && (cnt == MAX_CNT);

    // Acks are forwarded only while a request is outstanding.
    // Any other ack is stray and is dropped.
    assign ack_ok  = granted && i_s_wb_ack && cnt_nz;
    assign accept  = o_s_wb_stb && !i_s_wb_stall;
    assign dec     = ack_ok || tmo;
    assign release_grant = granted && !m_cyc;

    assign o_grant = {state == GRANT1, state == GRANT0};

`ifdef MATRIX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt;

    assign tmo = granted && cnt_nz && !i_s_wb_ack && (tcnt == TMO_MAX);
    assign o_timeout = tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (!granted || release_grant || i_s_wb_ack || tmo || !cnt_nz) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Slave side: the granted master's request, with stb masked at the limit.
    always_comb begin
        o_s_wb_cyc   = 1'b0;
        o_s_wb_stb   = 1'b0;
        o_s_wb_we    = 1'b0;
        o_s_wb_addr  = '0;
        o_s_wb_sel   = '0;
        o_s_wb_wdata = '0;
        if (granted) begin
            o_s_wb_cyc   = m_cyc;
            o_s_wb_stb   = m_cyc && m_stb && !limit;
            o_s_wb_we    = m_we;
            o_s_wb_addr  = m_addr;
            o_s_wb_sel   = m_sel;
            o_s_wb_wdata = m_wdata;
        end
    end

    // Master side: only the granted master sees the slave.
    // The other master is held stalled.
    always_comb begin
        o_m0_wb_ack   = 1'b0;
        o_m0_wb_stall = 1'b1;
        o_m0_wb_rdata = '0;
        o_m1_wb_ack   = 1'b0;
        o_m1_wb_stall = 1'b1;
        o_m1_wb_rdata = '0;
        if (state == GRANT0) begin
            o_m0_wb_ack   = ack_ok || tmo;
            o_m0_wb_stall = i_s_wb_stall || limit;
            o_m0_wb_rdata = tmo ? '0 : i_s_wb_rdata;
        end else if (state == GRANT1) begin
            o_m1_wb_ack   = ack_ok || tmo;
            o_m1_wb_stall = i_s_wb_stall || limit;
            o_m1_wb_rdata = tmo ? '0 : i_s_wb_rdata;
        end
    end

    // Next state. On a tie the master that was not served last wins.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (i_m0_wb_cyc && (!i_m1_wb_cyc || last)) begin
                    state_nxt = GRANT0;
                    last_nxt  = 1'b0;
                end else if (i_m1_wb_cyc) begin
                    state_nxt = GRANT1;
                    last_nxt  = 1'b1;
                end
            end
            GRANT0: begin
                if (!i_m0_wb_cyc) state_nxt = IDLE;
            end
            GRANT1: begin
                if (!i_m1_wb_cyc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outstanding count. An accept and an ack in the same cycle leave it unchanged.
    always_comb begin
        cnt_nxt = cnt;
        if (release_grant) begin
            cnt_nxt = '0;
        end else if (accept && !dec) begin
            cnt_nxt = cnt + CW'(1);
        end else if (dec && !accept) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The count must never wrap in either direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(dec && !cnt_nz));
            assert (!(accept && (cnt == MAX_CNT)));
        end
    end

endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// Scoreboard bench for matrix_wb_arbiter.
// Directed stimulus pushes the expected slave requests and master acks; a negedge monitor pops and compares.

module tb_matrix_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          m_cyc   [2];
    logic          m_stb   [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [SW-1:0] m_sel   [2];
    logic [DW-1:0] m_wdata [2];

    logic          m0_ack, m0_stall, m1_ack, m1_stall;
    logic [DW-1:0] m0_rdata, m1_rdata;

    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdata;
    logic          s_ack, s_stall;
    logic [DW-1:0] s_rdata;
    logic [1:0]    grant;

    matrix_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .i_m0_wb_cyc   (m_cyc[0]),
        .i_m0_wb_stb   (m_stb[0]),
        .i_m0_wb_we    (m_we[0]),
        .i_m0_wb_addr  (m_addr[0]),
        .i_m0_wb_sel   (m_sel[0]),
        .i_m0_wb_wdata (m_wdata[0]),
        .o_m0_wb_ack   (m0_ack),
        .o_m0_wb_stall (m0_stall),
        .o_m0_wb_rdata (m0_rdata),
        .i_m1_wb_cyc   (m_cyc[1]),
        .i_m1_wb_stb   (m_stb[1]),
        .i_m1_wb_we    (m_we[1]),
        .i_m1_wb_addr  (m_addr[1]),
        .i_m1_wb_sel   (m_sel[1]),
        .i_m1_wb_wdata (m_wdata[1]),
        .o_m1_wb_ack   (m1_ack),
        .o_m1_wb_stall (m1_stall),
        .o_m1_wb_rdata (m1_rdata),
        .o_s_wb_cyc    (s_cyc),
        .o_s_wb_stb    (s_stb),
        .o_s_wb_we     (s_we),
        .o_s_wb_addr   (s_addr),
        .o_s_wb_sel    (s_sel),
        .o_s_wb_wdata  (s_wdata),
        .i_s_wb_ack    (s_ack),
        .i_s_wb_stall  (s_stall),
        .i_s_wb_rdata  (s_rdata),
        .o_grant       (grant)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdata;
    } sreq_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] rdata;
    } mresp_t;

    sreq_t  sq[$];
    mresp_t mq[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic stall_of(input int n);
        return (n != 0) ? m1_stall : m0_stall;
    endfunction

    function automatic logic ack_of(input int n);
        return (n != 0) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int n);
        return (n != 0) ? m1_rdata : m0_rdata;
    endfunction

    // Monitor: every slave accept and every master ack must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_stb && !s_stall) begin
                if (sq.size() == 0) begin
                    unexpected("slave_req_unexpected");
                end else begin
                    sreq_t e;
                    e = sq.pop_front();
                    check("slave_req", {s_we, s_addr, s_sel, s_wdata}, e);
                end
            end
            if (m0_ack) begin
                if (mq.size() == 0) begin
                    unexpected("m0_ack_unexpected");
                end else begin
                    mresp_t e;
                    e = mq.pop_front();
                    check("m0_ack_owner", 64'(1'b0), 64'(e.id));
                    check("m0_rdata", m0_rdata, e.rdata);
                end
            end
            if (m1_ack) begin
                if (mq.size() == 0) begin
                    unexpected("m1_ack_unexpected");
                end else begin
                    mresp_t e;
                    e = mq.pop_front();
                    check("m1_ack_owner", 64'(1'b1), 64'(e.id));
                    check("m1_rdata", m1_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    function automatic sreq_t rd_req(input int n);
        sreq_t r;
        r.we    = 1'b0;
        r.addr  = m_addr[n];
        r.sel   = m_sel[n];
        r.wdata = m_wdata[n];
        return r;
    endfunction

    // Entered in the first cycle of master n's grant, with its stb already high.
    // Does one read and releases the bus; returns in the following IDLE cycle.
    task automatic serve(input int n, input logic [DW-1:0] rd);
        int o;
        mresp_t r;
        o = 1 - n;
        sq.push_back(rd_req(n));
        neg();
        check("serve_grant", grant, (n != 0) ? 2'b10 : 2'b01);
        check("serve_own_stall", stall_of(n), 1'b0);
        check("serve_other_stall", stall_of(o), 1'b1);
        check("serve_other_ack", ack_of(o), 1'b0);
        tick();
        m_stb[n] = 1'b0;
        s_ack    = 1'b1;
        s_rdata  = rd;
        r.id     = 1'(n);
        r.rdata  = rd;
        mq.push_back(r);
        neg();
        check("serve_other_ack2", ack_of(o), 1'b0);
        check("serve_other_rdata", rdata_of(o), '0);
        check("serve_other_stall2", stall_of(o), 1'b1);
        tick();
        s_ack    = 1'b0;
        s_rdata  = '0;
        m_cyc[n] = 1'b0;
        neg();
        check("serve_release_cyc", s_cyc, 1'b0);
        tick();
    endtask

    task automatic push_resp(input int n, input logic [DW-1:0] rd);
        mresp_t r;
        r.id    = 1'(n);
        r.rdata = rd;
        mq.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic last;
        int   w;
        sreq_t wr;

        for (int i = 0; i < 2; i++) begin
            m_cyc[i]   = 1'b0;
            m_stb[i]   = 1'b0;
            m_we[i]    = 1'b0;
            m_addr[i]  = '0;
            m_sel[i]   = 4'hF;
            m_wdata[i] = '0;
        end
        s_ack   = 1'b0;
        s_stall = 1'b0;
        s_rdata = 32'hDEAD_BEEF;
        reset   = 1'b1;
        repeat (3) tick();

        // Reset state; slave rdata is non-zero but must not leak through.
        neg();
        check("rst_grant", grant, 2'b00);
        check("rst_s_cyc", s_cyc, 1'b0);
        check("rst_s_stb", s_stb, 1'b0);
        check("rst_m0_stall", m0_stall, 1'b1);
        check("rst_m1_stall", m1_stall, 1'b1);
        check("rst_m0_ack", m0_ack, 1'b0);
        check("rst_m0_rdata", m0_rdata, '0);
        tick();
        reset   = 1'b0;
        s_rdata = '0;

        // Single m0 write; the slave stalls the first granted cycle.
        m_cyc[0]   = 1'b1;
        m_stb[0]   = 1'b1;
        m_we[0]    = 1'b1;
        m_addr[0]  = 3'd3;
        m_sel[0]   = 4'hF;
        m_wdata[0] = 32'h1234_5678;
        s_stall    = 1'b1;
        neg();
        check("t1_arb_latency", grant, 2'b00);
        check("t1_idle_stall", m0_stall, 1'b1);
        tick();
        neg();
        check("t1_grant", grant, 2'b01);
        check("t1_s_cyc", s_cyc, 1'b1);
        check("t1_slave_stall", m0_stall, 1'b1);
        tick();
        s_stall  = 1'b0;
        wr.we    = 1'b1;
        wr.addr  = 3'd3;
        wr.sel   = 4'hF;
        wr.wdata = 32'h1234_5678;
        sq.push_back(wr);
        neg();
        check("t1_accept_stall", m0_stall, 1'b0);
        tick();
        m_stb[0] = 1'b0;
        m_we[0]  = 1'b0;
        m_wdata[0] = '0;
        s_ack    = 1'b1;
        push_resp(0, '0);
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        neg();
        check("t1_cyc_drop", s_cyc, 1'b0);
        check("t1_grant_hold", grant, 2'b01);
        tick();
        neg();
        check("t1_back_idle", grant, 2'b00);

        // Simultaneous requests; m0 was served last, so m1 wins each tie.
        last = 1'b0;
        for (int rep = 0; rep < 4; rep++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
            end
            m_addr[0] = 3'(rep);
            m_addr[1] = 3'(rep + 4);
            neg();
            check("t2_tie_idle", grant, 2'b00);
            tick();
            w = last ? 0 : 1;
            serve(w, 32'hA000_0000 + 32'(rep));
            last = 1'(w);
            neg();
            check("t2_gap_idle", grant, 2'b00);
            tick();
            serve(1 - w, 32'hB000_0000 + 32'(rep));
            last = 1'(1 - w);
        end

        // Outstanding limit: m1 issues three back-to-back reads, acks held off.
        tick();
        m_cyc[1]  = 1'b1;
        m_stb[1]  = 1'b1;
        m_addr[1] = 3'd0;
        neg();
        check("t3_idle", grant, 2'b00);
        tick();
        sq.push_back(rd_req(1));
        neg();
        check("t3_grant", grant, 2'b10);
        check("t3_acc0", m1_stall, 1'b0);
        tick();
        m_addr[1] = 3'd1;
        sq.push_back(rd_req(1));
        neg();
        check("t3_acc1", m1_stall, 1'b0);
        tick();
        m_addr[1] = 3'd2;
        neg();
        check("t3_limit_stall", m1_stall, 1'b1);
        check("t3_limit_stb", s_stb, 1'b0);
        tick();
        neg();
        check("t3_limit_stall2", m1_stall, 1'b1);
        check("t3_limit_stb2", s_stb, 1'b0);
        tick();
        s_ack   = 1'b1;
        s_rdata = 32'hC0;
        push_resp(1, 32'hC0);
        neg();
        check("t3_ack_cycle_stall", m1_stall, 1'b1);
        tick();
        s_rdata = 32'hC1;
        push_resp(1, 32'hC1);
        sq.push_back(rd_req(1));
        neg();
        check("t3_acc2", m1_stall, 1'b0);
        check("t3_acc2_stb", s_stb, 1'b1);
        tick();
        m_stb[1] = 1'b0;
        s_rdata  = 32'hC2;
        push_resp(1, 32'hC2);
        neg();
        check("t3_simul_unchanged", m1_stall, 1'b0);
        tick();
        s_rdata = 32'hBAD0;
        neg();
        check("t4_stray_in_grant", m1_ack, 1'b0);
        tick();
        s_ack     = 1'b0;
        m_stb[1]  = 1'b1;
        m_addr[1] = 3'd5;
        sq.push_back(rd_req(1));
        neg();
        check("t4_after_stray0", m1_stall, 1'b0);
        tick();
        m_addr[1] = 3'd6;
        sq.push_back(rd_req(1));
        neg();
        check("t4_after_stray1", m1_stall, 1'b0);
        tick();
        m_stb[1] = 1'b0;
        s_ack    = 1'b1;
        s_rdata  = 32'hD5;
        push_resp(1, 32'hD5);
        neg();
        check("t4_count_two", m1_stall, 1'b1);
        tick();
        s_rdata = 32'hD6;
        push_resp(1, 32'hD6);
        tick();
        s_ack    = 1'b0;
        s_rdata  = '0;
        m_cyc[1] = 1'b0;
        tick();

        // Stray ack while idle.
        s_ack   = 1'b1;
        s_rdata = 32'hBAD1;
        neg();
        check("t4_idle_m0_ack", m0_ack, 1'b0);
        check("t4_idle_m1_ack", m1_ack, 1'b0);
        tick();
        s_ack   = 1'b0;
        s_rdata = '0;

        // Reset while m0 holds the grant with one request outstanding.
        tick();
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 1'b1;
        m_addr[0] = 3'd7;
        tick();
        sq.push_back(rd_req(0));
        neg();
        check("t5_grant", grant, 2'b01);
        tick();
        m_stb[0] = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        m_cyc[0] = 1'b0;
        s_ack    = 1'b1;
        s_rdata  = 32'hBAD2;
        neg();
        check("t5_grant_dropped", grant, 2'b00);
        check("t5_s_cyc", s_cyc, 1'b0);
        check("t5_s_stb", s_stb, 1'b0);
        check("t5_late_ack", m0_ack, 1'b0);
        tick();
        s_ack   = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b1;
            m_stb[i] = 1'b1;
        end
        m_addr[0] = 3'd1;
        m_addr[1] = 3'd2;
        neg();
        check("t5_tie_idle", grant, 2'b00);
        tick();
        serve(0, 32'hE0);
        tick();
        serve(1, 32'hE1);
        tick();

        check("end_slave_queue", 64'(sq.size()), 64'd0);
        check("end_master_queue", 64'(mq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
